// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32I instruction fields into 32-bit words and streams them,
// with sequential word addresses, to an instruction memory over a valid/ready handshake.
module instr_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        kind,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic              funct7b5,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              illegal_err,
    output logic [15:0]       instr_count
);
    typedef enum logic [3:0] {
        K_LOAD   = 4'd0,
        K_STORE  = 4'd1,
        K_RTYPE  = 4'd2,
        K_ITYPE  = 4'd3,
        K_BRANCH = 4'd4,
        K_JAL    = 4'd5,
        K_JALR   = 4'd6,
        K_LUI    = 4'd7,
        K_AUIPC  = 4'd8
    } kind_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic        accept;
    logic        handshake;
    logic        legal;
    logic        shift_op;
    logic [31:0] enc;

    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign handshake = out_valid && out_ready;
    assign shift_op  = (funct3 == 3'b001) || (funct3 == 3'b101);
    // Branch and jump targets are halfword aligned, so an odd offset cannot be encoded.
    assign legal     = (kind <= K_AUIPC) &&
                       !(((kind == K_BRANCH) || (kind == K_JAL)) && imm[0]);

    always_comb begin
        enc = '0;
        case (kind)
            K_LOAD:   enc = {imm[11:0], rs1, funct3, rd, OP_LOAD};
            K_STORE:  enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
            K_RTYPE:  enc = {1'b0, funct7b5, 5'b0, rs2, rs1, funct3, rd, OP_RTYPE};
            K_ITYPE:  enc = shift_op ? {1'b0, funct7b5, 5'b0, imm[4:0], rs1, funct3, rd, OP_ITYPE}
                                     : {imm[11:0], rs1, funct3, rd, OP_ITYPE};
            K_BRANCH: enc = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
            K_JAL:    enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
            K_JALR:   enc = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
            K_LUI:    enc = {imm[31:12], rd, OP_LUI};
            K_AUIPC:  enc = {imm[31:12], rd, OP_AUIPC};
            default:  enc = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            instr       <= '0;
            wr_addr     <= '0;
            illegal_err <= 1'b0;
            instr_count <= '0;
        end else begin
            illegal_err <= accept && !legal;
            if (accept && legal) begin
                instr     <= enc;
                out_valid <= 1'b1;
            end else if (handshake) begin
                out_valid <= 1'b0;
            end
            if (handshake) begin
                wr_addr     <= wr_addr + 1'b1;
                instr_count <= (instr_count == 16'hFFFF) ? instr_count : instr_count + 16'd1;
            end
        end
    end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter ADDR_W, default 8, sets the instruction-memory word-address width.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  field set on the inputs is valid.
REQ-005 in_ready  output  1  encoder accepts the field set this cycle.
REQ-006 kind  input  4  0 LOAD, 1 STORE, 2 RTYPE, 3 ITYPE, 4 BRANCH, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC; 9-15 illegal.
REQ-007 rd, rs1, rs2  input  5 each  register indices.
REQ-008 funct3  input  3  funct3 field.
REQ-009 funct7b5  input  1  instr[30] for RTYPE and ITYPE shifts.
REQ-010 imm  input  32  immediate, sign-extended byte offset or value.
REQ-011 out_valid  output  1  instr/wr_addr hold a valid write.
REQ-012 out_ready  input  1  downstream memory takes the write.
REQ-013 instr  output  32  encoded RV32I word.
REQ-014 wr_addr  output  ADDR_W  word address of the held instr.
REQ-015 illegal_err  output  1  one-cycle pulse when an accepted field set is dropped.
REQ-016 instr_count  output  16  number of completed output handshakes.

Function
REQ-017 in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-018 An input accept (in_valid && in_ready) with a legal kind SHALL load instr and set out_valid on the next edge; latency is 1 cycle.
REQ-019 An output handshake (out_valid && out_ready) without a same-cycle legal accept SHALL clear out_valid.
REQ-020 A simultaneous output handshake and legal accept SHALL keep out_valid=1 and load the new instr, for full throughput.
REQ-021 While out_valid && !out_ready, instr, wr_addr and out_valid SHALL hold stable.
REQ-022 An accepted set with kind 9-15, or with BRANCH/JAL and imm[0]=1, SHALL be consumed without loading instr, SHALL pulse illegal_err for exactly 1 cycle on the next edge, and SHALL leave wr_addr and out_valid unaffected.
REQ-023 Opcodes: LOAD 0000011, STORE 0100011, RTYPE 0110011, ITYPE 0010011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
REQ-024 LOAD and ITYPE: {imm[11:0], rs1, funct3, rd, op}.
REQ-025 ITYPE with funct3 001 or 101: {1'b0, funct7b5, 5'b0, imm[4:0], rs1, funct3, rd, op}.
REQ-026 JALR: same as LOAD with funct3 forced to 000.
REQ-027 RTYPE: {1'b0, funct7b5, 5'b0, rs2, rs1, funct3, rd, op}.
REQ-028 STORE: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}.
REQ-029 BRANCH: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}.
REQ-030 JAL: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
REQ-031 LUI/AUIPC: {imm[31:12], rd, op}.
REQ-032 Fields unused by a format SHALL be ignored; no range checking beyond REQ-022.
REQ-033 wr_addr SHALL increment by 1 on each output handshake and wrap from 2^ADDR_W-1 to 0.
REQ-034 instr_count SHALL increment on each output handshake and saturate at 0xFFFF.

Reset
REQ-035 rst=1 at an edge SHALL force out_valid=0, instr=0, wr_addr=0, illegal_err=0, instr_count=0, regardless of in-flight handshakes.
REQ-036 A field set presented in the reset cycle SHALL be discarded; in_ready SHALL read 1 on the first cycle after reset deasserts.

Verification
REQ-037 ITYPE rd=1 rs1=0 funct3=0 imm=5, out_ready=1 -> next cycle out_valid=1, instr=0x00500093, wr_addr=0.
REQ-038 STORE rs1=1 rs2=2 funct3=010 imm=8, then BRANCH rs1=1 rs2=2 funct3=0 imm=-4, back-to-back -> instr 0x0020A423 then 0xFE208EE3, wr_addr 0 then 1.
REQ-039 JAL rd=1 imm=8 -> 0x008000EF; LUI rd=5 imm=0x12345000 -> 0x123452B7; JAL imm=7 -> illegal_err pulse, no out_valid, wr_addr unchanged.
REQ-040 out_ready=0 for 5 cycles after an accept -> in_ready=0, instr/wr_addr stable; on out_ready=1 a waiting input SHALL be accepted in the same cycle.
REQ-041 ADDR_W=2, 5 consecutive handshakes -> wr_addr sequence 0,1,2,3,0; instr_count=5.
REQ-042 rst asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0, wr_addr=0, instr_count=0.
